// File: rtl/lzx_seq_pkg.sv
// Shared types and the fixed 8-step test program for the dual D-FF sequencer.
// Program rows are {action, D1, EXP1}; channel 2 is derived from channel 1.
package lzx_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_SETTLE,
    S_CHECK,
    S_FIN
  } state_t;

  typedef enum logic [1:0] {
    ACT_CLR,
    ACT_PRE,
    ACT_CLK,
    ACT_BOTH
  } action_t;

  localparam int NUM_STEPS = 8;

  typedef struct packed {
    action_t act;
    logic    d1;
    logic    exp1;
  } step_t;

  function automatic step_t prog_step(input logic [2:0] idx);
    step_t s;
    case (idx)
      3'd0:    s = '{act: ACT_CLR,  d1: 1'b0, exp1: 1'b0};
      3'd1:    s = '{act: ACT_PRE,  d1: 1'b0, exp1: 1'b1};
      3'd2:    s = '{act: ACT_CLK,  d1: 1'b0, exp1: 1'b0};
      3'd3:    s = '{act: ACT_CLK,  d1: 1'b1, exp1: 1'b1};
      3'd4:    s = '{act: ACT_CLK,  d1: 1'b1, exp1: 1'b1};
      3'd5:    s = '{act: ACT_CLK,  d1: 1'b0, exp1: 1'b0};
      3'd6:    s = '{act: ACT_BOTH, d1: 1'b0, exp1: 1'b1};
      default: s = '{act: ACT_CLR,  d1: 1'b0, exp1: 1'b0};
    endcase
    return s;
  endfunction

  function automatic action_t prog_act(input logic [2:0] idx);
    step_t s;
    s = prog_step(idx);
    return s.act;
  endfunction

  function automatic logic prog_d1(input logic [2:0] idx);
    step_t s;
    s = prog_step(idx);
    return s.d1;
  endfunction

  function automatic logic prog_exp1(input logic [2:0] idx);
    step_t s;
    s = prog_step(idx);
    return s.exp1;
  endfunction

  // Channel 2 sees inverted data/expectation only on clocked steps.
  function automatic logic chan2(input action_t act, input logic v);
    return (act == ACT_CLK) ? ~v : v;
  endfunction

endpackage

// File: rtl/lzx_seq_timer.sv
// 4-bit loadable down-counter with zero flag; times both PULSE and SETTLE.
module lzx_seq_timer (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_load,
  input  logic [3:0] i_val,
  output logic       o_zero
);

  logic [3:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      r_cnt <= 4'd0;
    else if (i_load)
      r_cnt <= i_val;
    else if (r_cnt != 4'd0)
      r_cnt <= r_cnt - 4'd1;
  end

  assign o_zero = (r_cnt == 4'd0);

endmodule

// File: rtl/lzx_dff_pair_sequencer.sv
// Drives a dual D-FF through a fixed 8-step program and checks Q/Q_N per step.
// Optional macro LZX_SEQ_STOP_ON_ERR_EN: finish at the first mismatching CHECK.
module lzx_dff_pair_sequencer
  import lzx_seq_pkg::*;
#(
  parameter int PULSE_W  = 2,
  parameter int SETTLE_W = 2,
  parameter int ERR_W    = 5
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_q1,
  input  logic             i_q_n1,
  input  logic             i_q2,
  input  logic             i_q_n2,
  output logic             o_sd1,
  output logic             o_rd1,
  output logic             o_sd2,
  output logic             o_rd2,
  output logic             o_clk1,
  output logic             o_clk2,
  output logic             o_d1,
  output logic             o_d2,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
  output logic [ERR_W-1:0] o_err_cnt,
  output logic [2:0]       o_step
);

  state_t           r_state;
  logic             r_sd, r_rd, r_clk, r_d1, r_d2;
  logic             r_busy, r_done, r_pass;
  logic [ERR_W-1:0] r_err;
  logic [2:0]       r_step;

  logic             w_load, w_zero, w_stop, w_last;
  logic [3:0]       w_load_val;
  action_t          w_act, w_nact;
  logic             w_exp1, w_exp2, w_mm1, w_mm2;
  logic [1:0]       w_mm_cnt;
  logic [ERR_W:0]   w_sum;
  logic [ERR_W-1:0] w_err_next;
  logic [2:0]       w_nidx;
  logic             w_nd1;

  assign w_load     = (r_state == S_SETUP) || ((r_state == S_PULSE) && w_zero);
  assign w_load_val = (r_state == S_SETUP) ? 4'(PULSE_W - 1) : 4'(SETTLE_W - 1);

  lzx_seq_timer u_timer (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_load (w_load),
    .i_val  (w_load_val),
    .o_zero (w_zero)
  );

  assign w_act  = prog_act(r_step);
  assign w_exp1 = prog_exp1(r_step);
  assign w_exp2 = chan2(w_act, w_exp1);
  assign w_nidx = r_step + 3'd1;
  assign w_nact = prog_act(w_nidx);
  assign w_nd1  = prog_d1(w_nidx);
  assign w_last = (r_step == 3'(NUM_STEPS - 1));

  assign w_mm1    = (i_q1 != w_exp1) || (i_q_n1 != ~w_exp1);
  assign w_mm2    = (i_q2 != w_exp2) || (i_q_n2 != ~w_exp2);
  assign w_mm_cnt = {1'b0, w_mm1} + {1'b0, w_mm2};
  assign w_sum    = {1'b0, r_err} + {{(ERR_W - 1){1'b0}}, w_mm_cnt};
  // Saturate rather than wrap so a large count never reads as a pass.
  assign w_err_next = w_sum[ERR_W] ? {ERR_W{1'b1}} : w_sum[ERR_W-1:0];

`ifdef LZX_SEQ_STOP_ON_ERR_EN
  assign w_stop = (w_mm_cnt != 2'd0);
`else
  assign w_stop = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_sd    <= 1'b1;
      r_rd    <= 1'b1;
      r_clk   <= 1'b0;
      r_d1    <= 1'b0;
      r_d2    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_err   <= '0;
      r_step  <= 3'd0;
    end else begin
      case (r_state)
        S_IDLE, S_FIN: begin
          if (i_start) begin
            r_err   <= '0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_step  <= 3'd0;
            r_busy  <= 1'b1;
            r_d1    <= prog_d1(3'd0);
            r_d2    <= chan2(prog_act(3'd0), prog_d1(3'd0));
            r_state <= S_SETUP;
          end
        end
        S_SETUP: begin
          case (w_act)
            ACT_CLR:  r_rd  <= 1'b0;
            ACT_PRE:  r_sd  <= 1'b0;
            ACT_CLK:  r_clk <= 1'b1;
            default: begin
              r_sd <= 1'b0;
              r_rd <= 1'b0;
            end
          endcase
          r_state <= S_PULSE;
        end
        S_PULSE: begin
          if (w_zero) begin
            r_sd    <= 1'b1;
            r_rd    <= 1'b1;
            r_clk   <= 1'b0;
            r_state <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (w_zero)
            r_state <= S_CHECK;
        end
        S_CHECK: begin
          r_err <= w_err_next;
          if (w_last || w_stop) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_err_next == '0);
            r_d1    <= 1'b0;
            r_d2    <= 1'b0;
            r_state <= S_FIN;
          end else begin
            r_step  <= w_nidx;
            r_d1    <= w_nd1;
            r_d2    <= chan2(w_nact, w_nd1);
            r_state <= S_SETUP;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Both channels share one set of pulse registers so they stay in lock-step.
  assign o_sd1     = r_sd;
  assign o_sd2     = r_sd;
  assign o_rd1     = r_rd;
  assign o_rd2     = r_rd;
  assign o_clk1    = r_clk;
  assign o_clk2    = r_clk;
  assign o_d1      = r_d1;
  assign o_d2      = r_d2;
  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_pass    = r_pass;
  assign o_err_cnt = r_err;
  assign o_step    = r_step;

endmodule

// File: tb/tb_lzx_dff_pair_sequencer.sv
// Scoreboard bench: golden dual D-FF models on a default and a fast/narrow instance.
// Expected run results are queued at START and compared when DONE rises.
module tb_lzx_dff_pair_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start_a, start_b, sel;
  logic fa_stuck, fa_swap, fb_swap;

  // instance A: defaults
  logic a_q1, a_qn1, a_q2, a_qn2;
  logic a_sd1, a_rd1, a_sd2, a_rd2, a_clk1, a_clk2, a_d1, a_d2;
  logic a_busy, a_done, a_pass;
  logic [4:0] a_err;
  logic [2:0] a_step;

  // instance B: PULSE_W=1, SETTLE_W=1, ERR_W=3
  logic b_q1, b_qn1, b_q2, b_qn2;
  logic b_sd1, b_rd1, b_sd2, b_rd2, b_clk1, b_clk2, b_d1, b_d2;
  logic b_busy, b_done, b_pass;
  logic [2:0] b_err;
  logic [2:0] b_step;

  lzx_dff_pair_sequencer dut_a (
    .i_clk(clk), .i_rst(rst), .i_start(start_a),
    .i_q1(a_q1), .i_q_n1(a_qn1), .i_q2(a_q2), .i_q_n2(a_qn2),
    .o_sd1(a_sd1), .o_rd1(a_rd1), .o_sd2(a_sd2), .o_rd2(a_rd2),
    .o_clk1(a_clk1), .o_clk2(a_clk2), .o_d1(a_d1), .o_d2(a_d2),
    .o_busy(a_busy), .o_done(a_done), .o_pass(a_pass),
    .o_err_cnt(a_err), .o_step(a_step)
  );

  lzx_dff_pair_sequencer #(.PULSE_W(1), .SETTLE_W(1), .ERR_W(3)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_start(start_b),
    .i_q1(b_q1), .i_q_n1(b_qn1), .i_q2(b_q2), .i_q_n2(b_qn2),
    .o_sd1(b_sd1), .o_rd1(b_rd1), .o_sd2(b_sd2), .o_rd2(b_rd2),
    .o_clk1(b_clk1), .o_clk2(b_clk2), .o_d1(b_d1), .o_d2(b_d2),
    .o_busy(b_busy), .o_done(b_done), .o_pass(b_pass),
    .o_err_cnt(b_err), .o_step(b_step)
  );

  // Golden D flip-flops: preset wins over clear, Q_N is always ~Q.
  logic ma1 = 1'b0, ma2 = 1'b0, mb1 = 1'b0, mb2 = 1'b0;
  always @(posedge a_clk1 or negedge a_sd1 or negedge a_rd1)
    if (!a_sd1) ma1 <= 1'b1; else if (!a_rd1) ma1 <= 1'b0; else ma1 <= a_d1;
  always @(posedge a_clk2 or negedge a_sd2 or negedge a_rd2)
    if (!a_sd2) ma2 <= 1'b1; else if (!a_rd2) ma2 <= 1'b0; else ma2 <= a_d2;
  always @(posedge b_clk1 or negedge b_sd1 or negedge b_rd1)
    if (!b_sd1) mb1 <= 1'b1; else if (!b_rd1) mb1 <= 1'b0; else mb1 <= b_d1;
  always @(posedge b_clk2 or negedge b_sd2 or negedge b_rd2)
    if (!b_sd2) mb2 <= 1'b1; else if (!b_rd2) mb2 <= 1'b0; else mb2 <= b_d2;

  assign a_q1  = fa_stuck ? 1'b0 : (fa_swap ? ~ma1 : ma1);
  assign a_qn1 = fa_swap ? ma1 : ~ma1;
  assign a_q2  = fa_swap ? ~ma2 : ma2;
  assign a_qn2 = fa_swap ? ma2 : ~ma2;
  assign b_q1  = fb_swap ? ~mb1 : mb1;
  assign b_qn1 = fb_swap ? mb1 : ~mb1;
  assign b_q2  = fb_swap ? ~mb2 : mb2;
  assign b_qn2 = fb_swap ? mb2 : ~mb2;

  logic       m_busy, m_done, m_pass, m_clk1;
  logic [4:0] m_err;
  logic [2:0] m_step;
  assign m_busy = sel ? b_busy : a_busy;
  assign m_done = sel ? b_done : a_done;
  assign m_pass = sel ? b_pass : a_pass;
  assign m_clk1 = sel ? b_clk1 : a_clk1;
  assign m_err  = sel ? {2'b00, b_err} : a_err;
  assign m_step = sel ? b_step : a_step;

  typedef struct {
    int cyc;
    int pass;
    int err;
    int step;
    int clkhi;
  } exp_t;

  exp_t sbq[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic check(input string tag, input int obs, input int exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic run_prog(input logic s, input string name, input exp_t e);
    int   n;
    int   hi;
    exp_t g;
    sel = s;
    @(negedge clk);
    sbq.push_back(e);
    if (s) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
    n  = 1;
    hi = 0;
    check({name, "_busy_c1"}, int'(m_busy), 1);
    check({name, "_done_clr"}, int'(m_done), 0);
    while (!m_done && n < 200) begin
      if (m_clk1) hi++;
      @(posedge clk); #1;
      n++;
    end
    g = sbq.pop_front();
    $display("run %s: done_cycle=%0d pass=%0d err=%0d step=%0d clk1_high=%0d",
             name, n, m_pass, m_err, m_step, hi);
    check({name, "_done_cyc"}, n, g.cyc);
    check({name, "_pass"}, int'(m_pass), g.pass);
    check({name, "_err"}, int'(m_err), g.err);
    check({name, "_step"}, int'(m_step), g.step);
    check({name, "_clk1_hi"}, hi, g.clkhi);
    check({name, "_busy_end"}, int'(m_busy), 0);
  endtask

  initial begin
    int n;
    int found;
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; sel = 1'b0;
    fa_stuck = 1'b0; fa_swap = 1'b0; fb_swap = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sd1", int'(a_sd1), 1);
    check("rst_rd2", int'(a_rd2), 1);
    check("rst_clk1", int'(a_clk1), 0);
    check("rst_d1", int'(a_d1), 0);
    check("rst_busy", int'(a_busy), 0);
    check("rst_done", int'(a_done), 0);
    check("rst_pass", int'(a_pass), 0);
    check("rst_err", int'(a_err), 0);
    check("rst_step", int'(a_step), 0);
    @(negedge clk);
    rst = 1'b0;

    run_prog(1'b0, "a_golden", '{cyc: 49, pass: 1, err: 0, step: 7, clkhi: 8});

    fa_stuck = 1'b1;
`ifdef LZX_SEQ_STOP_ON_ERR_EN
    run_prog(1'b0, "a_stuck", '{cyc: 13, pass: 0, err: 1, step: 1, clkhi: 0});
`else
    run_prog(1'b0, "a_stuck", '{cyc: 49, pass: 0, err: 4, step: 7, clkhi: 8});
`endif
    fa_stuck = 1'b0;

    fa_swap = 1'b1;
`ifdef LZX_SEQ_STOP_ON_ERR_EN
    run_prog(1'b0, "a_swap", '{cyc: 7, pass: 0, err: 2, step: 0, clkhi: 0});
`else
    run_prog(1'b0, "a_swap", '{cyc: 49, pass: 0, err: 16, step: 7, clkhi: 8});
`endif
    fa_swap = 1'b0;

    run_prog(1'b1, "b_golden", '{cyc: 33, pass: 1, err: 0, step: 7, clkhi: 4});

    fb_swap = 1'b1;
`ifdef LZX_SEQ_STOP_ON_ERR_EN
    run_prog(1'b1, "b_swap_sat", '{cyc: 5, pass: 0, err: 2, step: 0, clkhi: 0});
`else
    run_prog(1'b1, "b_swap_sat", '{cyc: 33, pass: 0, err: 7, step: 7, clkhi: 4});
`endif
    fb_swap = 1'b0;

    // Reset in the middle of step 3's clock pulse.
    sel = 1'b0;
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    found = 0;
    for (int i = 0; i < 100; i++) begin
      if (a_step == 3'd3 && a_clk1) begin
        found = 1;
        break;
      end
      @(posedge clk); #1;
    end
    check("midrst_reached", found, 1);
    rst = 1'b1;
    #1;
    check("midrst_clk1", int'(a_clk1), 0);
    check("midrst_clk2", int'(a_clk2), 0);
    check("midrst_sd1", int'(a_sd1), 1);
    check("midrst_rd1", int'(a_rd1), 1);
    check("midrst_busy", int'(a_busy), 0);
    check("midrst_step", int'(a_step), 0);
    @(negedge clk);
    rst = 1'b0;
    run_prog(1'b0, "a_after_rst", '{cyc: 49, pass: 1, err: 0, step: 7, clkhi: 8});

    // START held high: ignored while busy, restarts on the first FIN cycle.
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk); #1;
    n = 1;
    while (!a_done && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    $display("run a_hold: done_cycle=%0d pass=%0d err=%0d", n, a_pass, a_err);
    check("hold_done_cyc", n, 49);
    check("hold_pass", int'(a_pass), 1);
    @(posedge clk); #1;
    check("hold_restart_done", int'(a_done), 0);
    check("hold_restart_busy", int'(a_busy), 1);
    check("hold_restart_step", int'(a_step), 0);
    start_a = 1'b0;
    n = 0;
    while (!a_done && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    $display("run a_rerun: cycles_after_restart=%0d pass=%0d err=%0d", n, a_pass, a_err);
    check("hold_rerun_cyc", n, 48);
    check("hold_rerun_pass", int'(a_pass), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
